// File: rtl/sub8bits_serial_pkg.sv
// sub8bits_pkg: shared FSM states, default width and counter sizing for sub8bits_serial.
package sub8bits_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam int DEFAULT_WIDTH = 8;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return (r < 1) ? 1 : r;
  endfunction
endpackage

// File: rtl/sub8bits_serial_full_sub1.sv
// full_sub1: combinational 1-bit full subtractor, d = x - y - bi with borrow-out bo.
module full_sub1 (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);
  always_comb begin
    d = x ^ y ^ bi;
    bo = (~x & y) | (~(x ^ y) & bi);
  end
endmodule

// File: rtl/sub8bits_serial.sv
// sub8bits_serial: bit-serial LSB-first subtractor with start/busy/done handshake.
// Define SUB8BITS_SERIAL_OVF_EN to add the signed-overflow output ovf.
module sub8bits_serial
  import sub8bits_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
`ifdef SUB8BITS_SERIAL_OVF_EN
  output logic             ovf,
`endif
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);
  localparam int CW = clog2(WIDTH);
  state_t state, next;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] sa, sb;
  logic [WIDTH-2:0] sr;
  logic br, d, bo, last;
  assign last = cnt == CW'(WIDTH - 1);
  full_sub1 u_cell (.x(sa[0]), .y(sb[0]), .bi(br), .d(d), .bo(bo));
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= next;
  always_comb
    next = state == IDLE  ? (start ? SHIFT : IDLE) :
           state == SHIFT ? (last ? DONE : SHIFT) : IDLE;
  always_comb begin
    busy = state != IDLE;
    done = state == DONE;
  end
  // diff/borrow only load on the final bit so partial results never show
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sa <= '0;
      sb <= '0;
      sr <= '0;
      br <= 1'b0;
      cnt <= '0;
      diff <= '0;
      borrow <= 1'b0;
`ifdef SUB8BITS_SERIAL_OVF_EN
      ovf <= 1'b0;
`endif
    end else if (state == IDLE && start) begin
      sa <= a;
      sb <= b;
      br <= bin;
      cnt <= '0;
    end else if (state == SHIFT) begin
      sa <= sa >> 1;
      sb <= sb >> 1;
      br <= bo;
      sr <= (WIDTH-1)'({d, sr} >> 1);
      cnt <= cnt + CW'(1);
      if (last) begin
        diff <= {d, sr};
        borrow <= bo;
`ifdef SUB8BITS_SERIAL_OVF_EN
        ovf <= br ^ bo;
`endif
      end
    end
endmodule

// File: tb/tb_sub8bits_serial.sv
// tb_sub8bits_serial: directed self-checking bench for sub8bits_serial (WIDTH=8).
module tb_sub8bits_serial;
  logic clk = 1'b0, rst = 1'b0, start = 1'b0, bin = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic busy, done, borrow;
  logic [7:0] diff;
`ifdef SUB8BITS_SERIAL_OVF_EN
  logic ovf;
`endif
  int checks = 0, errors = 0;

  sub8bits_serial #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy), .done(done),
`ifdef SUB8BITS_SERIAL_OVF_EN
    .ovf(ovf),
`endif
    .diff(diff), .borrow(borrow)
  );

  always #5 clk = ~clk;

  // called 1 time unit after a rising edge; returns edges from accept to done
  task automatic do_op(input logic [7:0] ta, input logic [7:0] tb, input logic tbin,
                       output int lat, output logic [7:0] mid);
    a = ta; b = tb; bin = tbin; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    mid = diff;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 4) mid = diff;
    end
  endtask

  task automatic test_reset;
    #2 rst = 1'b1; #1;
    checks += 4;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    if (diff !== 8'h00) begin errors++; $display("FAIL reset_diff got %h want 00", diff); end
    if (borrow !== 1'b0) begin errors++; $display("FAIL reset_borrow got %b want 0", borrow); end
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checks += 4;
    if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", busy); end
    if (done !== 1'b0) begin errors++; $display("FAIL idle_done got %b want 0", done); end
    if (diff !== 8'h00) begin errors++; $display("FAIL idle_diff got %h want 00", diff); end
    if (borrow !== 1'b0) begin errors++; $display("FAIL idle_borrow got %b want 0", borrow); end
  endtask

  task automatic test_basic;
    int lat;
    logic [7:0] mid;
    do_op(8'h05, 8'h03, 1'b0, lat, mid);
    checks += 4;
    if (lat !== 8) begin errors++; $display("FAIL basic_latency got %0d want 8", lat); end
    if (mid !== 8'h00) begin errors++; $display("FAIL basic_mid_diff got %h want 00", mid); end
    if (diff !== 8'h02) begin errors++; $display("FAIL basic_diff got %h want 02", diff); end
    if (borrow !== 1'b0) begin errors++; $display("FAIL basic_borrow got %b want 0", borrow); end
    @(posedge clk); #1;
    checks += 3;
    if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got %b want 0", done); end
    if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after got %b want 0", busy); end
    if (diff !== 8'h02) begin errors++; $display("FAIL basic_hold got %h want 02", diff); end
  endtask

  task automatic test_underflow;
    int lat;
    logic [7:0] mid;
    do_op(8'h00, 8'h01, 1'b0, lat, mid);
    checks += 2;
    if (diff !== 8'hFF) begin errors++; $display("FAIL under_diff got %h want ff", diff); end
    if (borrow !== 1'b1) begin errors++; $display("FAIL under_borrow got %b want 1", borrow); end
    @(posedge clk); #1;
    do_op(8'h10, 8'h0F, 1'b1, lat, mid);
    checks += 4;
    if (mid !== 8'hFF) begin errors++; $display("FAIL bin_mid_diff got %h want ff", mid); end
    if (lat !== 8) begin errors++; $display("FAIL bin_latency got %0d want 8", lat); end
    if (diff !== 8'h00) begin errors++; $display("FAIL bin_diff got %h want 00", diff); end
    if (borrow !== 1'b0) begin errors++; $display("FAIL bin_borrow got %b want 0", borrow); end
    @(posedge clk); #1;
  endtask

  task automatic test_overflow;
    int lat;
    logic [7:0] mid;
    do_op(8'h80, 8'h01, 1'b0, lat, mid);
    checks += 2;
    if (diff !== 8'h7F) begin errors++; $display("FAIL ovf1_diff got %h want 7f", diff); end
    if (borrow !== 1'b0) begin errors++; $display("FAIL ovf1_borrow got %b want 0", borrow); end
`ifdef SUB8BITS_SERIAL_OVF_EN
    checks++;
    if (ovf !== 1'b1) begin errors++; $display("FAIL ovf1_flag got %b want 1", ovf); end
`endif
    @(posedge clk); #1;
    do_op(8'h7F, 8'h01, 1'b0, lat, mid);
    checks += 2;
    if (diff !== 8'h7E) begin errors++; $display("FAIL ovf2_diff got %h want 7e", diff); end
    if (borrow !== 1'b0) begin errors++; $display("FAIL ovf2_borrow got %b want 0", borrow); end
`ifdef SUB8BITS_SERIAL_OVF_EN
    checks++;
    if (ovf !== 1'b0) begin errors++; $display("FAIL ovf2_flag got %b want 0", ovf); end
`endif
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    int t1, t2;
    t1 = -1; t2 = -1;
    a = 8'h20; b = 8'h05; bin = 1'b0; start = 1'b1;
    for (int cyc = 1; cyc <= 40 && t2 < 0; cyc++) begin
      @(posedge clk); #1;
      if (done) begin
        if (t1 < 0) t1 = cyc;
        else t2 = cyc;
      end
    end
    start = 1'b0;
    checks += 3;
    if (t1 !== 9) begin errors++; $display("FAIL b2b_first got %0d want 9", t1); end
    if (t2 - t1 !== 10) begin errors++; $display("FAIL b2b_gap got %0d want 10", t2 - t1); end
    if (diff !== 8'h1B) begin errors++; $display("FAIL b2b_diff got %h want 1b", diff); end
    @(posedge clk); #1;
  endtask

  task automatic test_operand_change;
    int lat;
    a = 8'h33; b = 8'h11; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = 8'hFF; b = 8'h00; bin = 1'b1;
    lat = 0;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 3) begin a = 8'h01; b = 8'hF0; end
    end
    checks += 3;
    if (lat !== 8) begin errors++; $display("FAIL chg_latency got %0d want 8", lat); end
    if (diff !== 8'h22) begin errors++; $display("FAIL chg_diff got %h want 22", diff); end
    if (borrow !== 1'b0) begin errors++; $display("FAIL chg_borrow got %b want 0", borrow); end
    // start raised during DONE must not begin a new operation
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks += 2;
    if (busy !== 1'b0) begin errors++; $display("FAIL done_start_busy got %b want 0", busy); end
    if (diff !== 8'h22) begin errors++; $display("FAIL done_start_diff got %h want 22", diff); end
  endtask

  task automatic test_reset_mid;
    int lat, seen;
    logic [7:0] mid;
    a = 8'h55; b = 8'h11; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1; #1;
    checks += 4;
    if (busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy got %b want 0", busy); end
    if (done !== 1'b0) begin errors++; $display("FAIL mid_rst_done got %b want 0", done); end
    if (diff !== 8'h00) begin errors++; $display("FAIL mid_rst_diff got %h want 00", diff); end
    if (borrow !== 1'b0) begin errors++; $display("FAIL mid_rst_borrow got %b want 0", borrow); end
    @(posedge clk);
    #2 rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done || busy) seen++;
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL mid_rst_no_done got %0d want 0", seen); end
    do_op(8'h55, 8'h11, 1'b0, lat, mid);
    checks += 3;
    if (lat !== 8) begin errors++; $display("FAIL after_rst_latency got %0d want 8", lat); end
    if (diff !== 8'h44) begin errors++; $display("FAIL after_rst_diff got %h want 44", diff); end
    if (borrow !== 1'b0) begin errors++; $display("FAIL after_rst_borrow got %b want 0", borrow); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset;
    @(posedge clk); #1;
    test_basic;
    test_underflow;
    test_overflow;
    test_back_to_back;
    test_operand_change;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
